main_control_fsm: RTL and testbench
===================================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction-register bits [31:26]; sampled only in DECODE.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag; sampled only in BRANCH.
REQ-005 SHALL have port mem_write, output, 1 bit: data memory write strobe.
REQ-006 SHALL have port ir_write, output, 1 bit: instruction register load.
REQ-007 SHALL have port reg_write, output, 1 bit: register file write.
REQ-008 SHALL have port iord, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
REQ-009 SHALL have ports reg_dst and mem_to_reg, outputs, 1 bit each: write-register and write-data selects.
REQ-010 SHALL have port alu_src_a, output, 1 bit: 0 = PC, 1 = register A.
REQ-011 SHALL have port alu_src_b, output, 2 bits: 3-to-1 mux select (00 = B, 01 = constant 4, 10 = sign-extended immediate); never 11.
REQ-012 SHALL have port pc_src, output, 2 bits: 3-to-1 mux select (00 = ALU result, 01 = ALUOut, 10 = jump target); never 11.
REQ-013 SHALL have port alu_op, output, 2 bits: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-014 SHALL have port pc_en, output, 1 bit: PC register load enable.
REQ-015 SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-016 SHALL have port instr_done, output, 1 bit: one-cycle pulse in the last state of each instruction.

Function
REQ-017 SHALL be a Moore machine: all outputs are decoded from the state register only; pc_en is the sole exception (REQ-020).
REQ-018 SHALL implement states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Transitions: IDLE->FETCH; FETCH->DECODE.
- DECODE on opcode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other opcode -> FETCH with illegal_op=1.
- MEMADR->MEMRD (lw) or MEMWR (sw), using the opcode latched in DECODE.
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
REQ-019 SHALL assert only the listed outputs in each state; all others are 0.
- FETCH: ir_write=1, alu_src_b=01, pc_write=1.
- DECODE: alu_src_b=10.
- MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
- MEMRD: iord=1.
- MEMWB: reg_write=1, mem_to_reg=1.
- MEMWR: iord=1, mem_write=1.
- EXECUTE: alu_src_a=1, alu_op=10.
- ALUWB: reg_write=1, reg_dst=1.
- ADDIWB: reg_write=1.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1.
- JUMP: pc_src=10, pc_write=1.
REQ-020 SHALL drive pc_en = pc_write | (branch & zero), with zero passing combinationally to pc_en.
REQ-021 SHALL set instr_done=1 in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
REQ-022 SHALL set the instruction latency (FETCH to return to FETCH) to: lw 5, sw/R-type/addi 4, beq/j 3 cycles.
REQ-023 SHALL drive every output to 0 in IDLE.

Reset
REQ-024 SHALL force the state to IDLE and all outputs to 0 asynchronously whenever rst_n=0, including mid-instruction; no memory or register write may occur while reset is held.
REQ-025 SHALL enter FETCH on the first rising edge after rst_n deasserts (via IDLE), so the first pc_en=1 occurs no earlier than the second edge after release.

Configuration
REQ-026 SHALL, when macro MAIN_CONTROL_BNE_EN is defined, decode opcode 000101 in DECODE to state BNEQ: outputs as BRANCH, but pc_en = pc_write | (branch_ne & ~zero); instr_done=1; BNEQ->FETCH.
REQ-027 SHALL, without MAIN_CONTROL_BNE_EN, treat opcode 000101 as illegal (REQ-018), and the BNEQ state SHALL NOT exist.

Verification
REQ-028 SHALL verify: rst_n low for 3 cycles then released -> outputs all 0 in IDLE, FETCH on the next edge with ir_write=1, pc_en=1, alu_src_b=01.
REQ-029 SHALL verify: opcode 100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; instr_done only in MEMWB; mem_to_reg=1, reg_write=1 there.
REQ-030 SHALL verify: opcode 000100 with zero=1 -> pc_en=1, pc_src=01 in BRANCH; with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
REQ-031 SHALL verify: opcode 111111 -> illegal_op=1 for exactly one cycle, next state FETCH, no reg_write or mem_write asserted.
REQ-032 SHALL verify: rst_n asserted in MEMWR -> mem_write drops to 0 immediately (no clock edge), then restart from IDLE.
REQ-033 SHALL verify: opcode 000101 with zero=0 -> pc_en=1 when MAIN_CONTROL_BNE_EN is defined; illegal_op=1 when it is not.

Source files
------------

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle MIPS-style main controller; Moore outputs decoded from the state register.
// Define MAIN_CONTROL_BNE_EN to add the BNEQ state for opcode 000101 (otherwise that opcode is illegal).
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       instr_done
);

    // state   | meaning
    // IDLE    | post-reset, all outputs low
    // FETCH   | load IR, PC <= PC + 4
    // DECODE  | register read, branch target computed, opcode dispatched
    // MEMADR  | lw/sw effective address
    // MEMRD   | lw data memory read
    // MEMWB   | lw register write-back
    // MEMWR   | sw data memory write
    // EXECUTE | R-type ALU operation
    // ALUWB   | R-type register write-back
    // BRANCH  | beq compare, PC <= target when zero
    // JUMP    | PC <= jump target
    // ADDIEX  | addi ALU operation
    // ADDIWB  | addi register write-back
    // BNEQ    | bne compare, PC <= target when not zero (optional)
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXECUTE = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JUMP    = 4'd10;
    localparam logic [3:0] S_ADDIEX  = 4'd11;
    localparam logic [3:0] S_ADDIWB  = 4'd12;
`ifdef MAIN_CONTROL_BNE_EN
    localparam logic [3:0] S_BNEQ    = 4'd13;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MAIN_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    logic [3:0] state_q, state_d;
    logic       is_sw_q, is_sw_d;
    logic       illegal_q, illegal_d;
    logic       pc_write;
    logic       branch;
`ifdef MAIN_CONTROL_BNE_EN
    logic       branch_ne;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_sw_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_sw_q   <= is_sw_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = (opcode == OP_SW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MAIN_CONTROL_BNE_EN
                    OP_BNE:       state_d = S_BNEQ;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                       state_d = S_FETCH;
`ifdef MAIN_CONTROL_BNE_EN
            S_BNEQ:    state_d = S_FETCH;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // illegal_op is registered so it stays a pure state decode; it pulses in the FETCH after the bad DECODE.
    assign illegal_op = illegal_q;

    always_comb begin
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
`ifdef MAIN_CONTROL_BNE_EN
        branch_ne  = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
            end
            S_DECODE: alu_src_b = 2'b10;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MAIN_CONTROL_BNE_EN
            S_BNEQ: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch_ne  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // zero feeds pc_en combinationally so the branch resolves in the same cycle as the compare.
`ifdef MAIN_CONTROL_BNE_EN
    assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
    assign pc_en = pc_write | (branch & zero);
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: hand sequences, a vector table and randomized instructions
// checked against a per-instruction behavioural model. Honours MAIN_CONTROL_BNE_EN.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_write, ir_write, reg_write, iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       pc_en, illegal_op, instr_done;
    logic [15:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .iord(iord),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
        .pc_en(pc_en), .illegal_op(illegal_op), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    assign outs = {mem_write, ir_write, reg_write, iord, reg_dst, mem_to_reg, alu_src_a,
                   alu_src_b, pc_src, alu_op, pc_en, illegal_op, instr_done};

    typedef struct {
        int cycles;
        int regw;
        int memw;
        int done;
        int done_last;
        int pcen;
        int ill;
        int badmux;
    } res_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        res_t       exp;
    } vec_t;

    function automatic logic [15:0] ov(input bit mw, input bit irw, input bit rw, input bit io,
                                       input bit rd, input bit m2r, input bit asa,
                                       input bit [1:0] asb, input bit [1:0] pcs, input bit [1:0] aop,
                                       input bit pce, input bit ill, input bit dn);
        return {mw, irw, rw, io, rd, m2r, asa, asb, pcs, aop, pce, ill, dn};
    endfunction

    function automatic res_t mk(input int cyc, input int rw, input int mw, input int dn,
                                input int pce, input int ill);
        res_t r;
        r.cycles = cyc; r.regw = rw; r.memw = mw; r.done = dn; r.done_last = dn;
        r.pcen = pce; r.ill = ill; r.badmux = 0;
        return r;
    endfunction

    // Instruction-level model: latency, write strobes and PC loads per instruction class.
    function automatic res_t model(input logic [5:0] op, input logic z);
        bit bne_en;
`ifdef MAIN_CONTROL_BNE_EN
        bne_en = 1'b1;
`else
        bne_en = 1'b0;
`endif
        case (op)
            6'b100011: return mk(5, 1, 0, 1, 1, 0);
            6'b101011: return mk(4, 0, 1, 1, 1, 0);
            6'b000000: return mk(4, 1, 0, 1, 1, 0);
            6'b001000: return mk(4, 1, 0, 1, 1, 0);
            6'b000100: return mk(3, 0, 0, 1, 1 + int'(z), 0);
            6'b000010: return mk(3, 0, 0, 1, 2, 0);
            6'b000101: begin
                if (bne_en) return mk(3, 0, 0, 1, 1 + int'(!z), 0);
                else        return mk(2, 0, 0, 0, 1, 1);
            end
            default:   return mk(2, 0, 0, 0, 1, 1);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction starting in FETCH, collecting per-cycle statistics until FETCH returns.
    task automatic run_instr(input logic [5:0] op, input logic z, output res_t r);
        opcode = op;
        zero   = z;
        #1;
        r = mk(0, 0, 0, 0, 0, 0);
        do begin
            r.cycles++;
            r.regw += int'(reg_write);
            r.memw += int'(mem_write);
            r.done += int'(instr_done);
            r.pcen += int'(pc_en);
            if (alu_src_b == 2'b11 || pc_src == 2'b11) r.badmux++;
            r.done_last = int'(instr_done);
            step();
        end while (!ir_write && r.cycles < 12);
        r.ill = int'(illegal_op);
    endtask

    task automatic cmp_res(input string tag, input res_t a, input res_t e);
        check({tag, " cycles"},    a.cycles,    e.cycles);
        check({tag, " reg_write"}, a.regw,      e.regw);
        check({tag, " mem_write"}, a.memw,      e.memw);
        check({tag, " done_cnt"},  a.done,      e.done);
        check({tag, " done_last"}, a.done_last, e.done_last);
        check({tag, " pc_en_cnt"}, a.pcen,      e.pcen);
        check({tag, " illegal"},   a.ill,       e.ill);
        check({tag, " mux_11"},    a.badmux,    e.badmux);
    endtask

    localparam logic [15:0] V_FETCH = 16'b0100000_01_00_00_100;

    initial begin
        vec_t tbl[10];
        res_t r;
        logic [5:0] rop;
        logic       rz;

        tbl[0] = '{6'b100011, 1'b0, mk(5, 1, 0, 1, 1, 0)};
        tbl[1] = '{6'b101011, 1'b1, mk(4, 0, 1, 1, 1, 0)};
        tbl[2] = '{6'b000000, 1'b1, mk(4, 1, 0, 1, 1, 0)};
        tbl[3] = '{6'b001000, 1'b0, mk(4, 1, 0, 1, 1, 0)};
        tbl[4] = '{6'b000100, 1'b1, mk(3, 0, 0, 1, 2, 0)};
        tbl[5] = '{6'b000100, 1'b0, mk(3, 0, 0, 1, 1, 0)};
        tbl[6] = '{6'b000010, 1'b0, mk(3, 0, 0, 1, 2, 0)};
        tbl[7] = '{6'b111111, 1'b0, mk(2, 0, 0, 0, 1, 1)};
`ifdef MAIN_CONTROL_BNE_EN
        tbl[8] = '{6'b000101, 1'b0, mk(3, 0, 0, 1, 2, 0)};
        tbl[9] = '{6'b000101, 1'b1, mk(3, 0, 0, 1, 1, 0)};
`else
        tbl[8] = '{6'b000101, 1'b0, mk(2, 0, 0, 0, 1, 1)};
        tbl[9] = '{6'b000101, 1'b1, mk(2, 0, 0, 0, 1, 1)};
`endif

        rst_n  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;

        // reset held 3 cycles, release away from the edge, FETCH on the next edge
        repeat (3) @(posedge clk);
        #2;
        check("reset_outs", outs, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("idle_outs", outs, 16'h0000);
        step();
        check("first_fetch", outs, V_FETCH);

        // lw walk-through
        opcode = 6'b100011;
        step(); check("lw_decode", outs, ov(0,0,0,0,0,0,0,2'b10,2'b00,2'b00,0,0,0));
        step(); check("lw_memadr", outs, ov(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0));
        step(); check("lw_memrd",  outs, ov(0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0));
        step(); check("lw_memwb",  outs, ov(0,0,1,0,0,1,0,2'b00,2'b00,2'b00,0,0,1));
        step(); check("lw_refetch", outs, V_FETCH);

        // beq: taken, then zero drops inside BRANCH
        opcode = 6'b000100;
        zero   = 1'b1;
        step(); step();
        check("beq_taken", outs, ov(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,1));
        zero = 1'b0;
        #1;
        check("beq_not_taken_pc_en", int'(pc_en), 0);
        step(); check("beq_refetch", int'(ir_write), 1);

        // illegal opcode: one-cycle pulse in the following FETCH
        opcode = 6'b111111;
        step(); step();
        check("illegal_fetch", outs, ov(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,1,1,0));
        opcode = 6'b000000;
        step(); check("illegal_cleared", int'(illegal_op), 0);
        step(); step(); step();
        check("rtype_refetch", outs, V_FETCH);

        // reset asserted during MEMWR
        opcode = 6'b101011;
        step(); step(); step();
        check("sw_memwr", outs, ov(1,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,1));
        #1 rst_n = 1'b0;
        #1 check("async_reset_memwr", outs, 16'h0000);
        repeat (2) @(posedge clk);
        #2 check("reset_hold", outs, 16'h0000);
        rst_n = 1'b1;
        #1 check("reset_release_idle", outs, 16'h0000);
        step(); check("restart_fetch", outs, V_FETCH);

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].z, r);
            cmp_res($sformatf("tbl%0d", i), r, tbl[i].exp);
        end

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: rop = 6'b100011;
                1: rop = 6'b101011;
                2: rop = 6'b000000;
                3: rop = 6'b001000;
                4: rop = 6'b000100;
                5: rop = 6'b000010;
                6: rop = 6'b000101;
                default: rop = 6'($urandom);
            endcase
            rz = 1'($urandom);
            run_instr(rop, rz, r);
            cmp_res($sformatf("rnd%0d_op%b_z%0d", n, rop, rz), r, model(rop, rz));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
